// File: rtl/uart_pkg.sv
// Shared definitions for the UART: register strobe indices, status/config bit
// positions, the bit-engine state enum and a parity helper.
package uart_pkg;

    localparam int W_TXDATA = 0;
    localparam int W_IE     = 1;
    localparam int W_DIVL   = 4;
    localparam int W_DIVH   = 5;
    localparam int W_CFG    = 6;

    localparam int R_RXDATA = 0;
    localparam int R_STAT   = 1;
    localparam int R_RXCNT  = 2;
    localparam int R_TXCNT  = 3;

    localparam int S_RXRDY   = 0;
    localparam int S_TXRDY   = 1;
    localparam int S_PERR    = 2;
    localparam int S_FERR    = 3;
    localparam int S_OVF     = 4;
    localparam int S_TOVF    = 5;
    localparam int S_TXEMPTY = 6;
    localparam int S_TXFULL  = 7;

    localparam int C_LOOP  = 0;
    localparam int C_OHEL  = 1;
    localparam int C_PEN   = 2;
    localparam int C_EIGHT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Parity bit that makes the frame even (odd=0) or odd (odd=1); bit 7 ignored for 7-bit data.
    function automatic logic calcParity(input logic [7:0] d, input logic eight, input logic odd);
        return (^(eight ? d : {1'b0, d[6:0]})) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO used for both UART directions; a push on a full FIFO only
// succeeds when a pop happens on the same edge.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPush = i_push && (!o_full || i_pop);
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_top.sv
// FIFO-buffered UART with programmable divisor, sticky error status and maskable interrupt.
// Define UART_LOOPBACK_EN to build the internal TX->RX loopback selected by CFG[0].
module uart_fifo_top
    import uart_pkg::*;
#(
    parameter int              DIVW     = 16,
    parameter logic [DIVW-1:0] DIV_RST  = 16'd433,
    parameter int              TX_DEPTH = 16,
    parameter int              RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] WRITES,
    input  logic [7:0] READS,
    input  logic [7:0] UDI,
    input  logic       RX,
    output logic       TX,
    output logic       UART_INT,
    output logic [7:0] UDO
);

    logic [3:0]      r_ie;
    logic [3:0]      r_cfg;
    logic [DIVW-1:0] r_div;
    logic            r_tovf, r_ovf, r_ferr, r_perr;
    logic [DIVW-1:0] w_div;
    logic [2:0]      w_lastIdx;
    logic [7:0]      w_status;
    logic            w_unused;

    logic [7:0]                  w_txData;
    logic [$clog2(TX_DEPTH):0]   w_txCount;
    logic                        w_txFull, w_txEmpty, w_txPush, w_txPop, w_txLoad, w_txBit, w_txTick;
    uart_state_e                 r_txState, w_txStateNext;
    logic [DIVW-1:0]             r_txCnt;
    logic [2:0]                  r_txIdx;
    logic [7:0]                  r_txShift;
    logic                        r_txPar, r_txPin;

    logic [7:0]                  w_rxData, w_rxByte;
    logic [$clog2(RX_DEPTH):0]   w_rxCount;
    logic                        w_rxFull, w_rxEmpty, w_rxPush, w_rxPop, w_rxTick, w_rxFall, w_rxIn;
    logic                        w_ferrSet, w_perrSet;
    uart_state_e                 r_rxState, w_rxStateNext;
    logic [DIVW-1:0]             r_rxCnt;
    logic [2:0]                  r_rxIdx;
    logic [7:0]                  r_rxShift;
    logic                        r_rxParBit, r_rxSync1, r_rxSync2, r_rxPrev;

    assign w_unused  = &{1'b0, WRITES[7], WRITES[3:2], READS[7:4], r_cfg[C_LOOP]};
    assign w_div     = (r_div == '0) ? DIVW'(1) : r_div;
    assign w_lastIdx = r_cfg[C_EIGHT] ? 3'd7 : 3'd6;
    assign w_txPush  = WRITES[W_TXDATA];
    assign w_rxPop   = READS[R_RXDATA];
    assign w_txTick  = (r_txCnt == '0);
    assign w_rxTick  = (r_rxCnt == '0);
    assign w_rxFall  = r_rxPrev & ~r_rxSync2;

`ifdef UART_LOOPBACK_EN
    assign TX     = r_cfg[C_LOOP] ? 1'b1 : r_txPin;
    assign w_rxIn = r_cfg[C_LOOP] ? r_txPin : RX;
`else
    assign TX     = r_txPin;
    assign w_rxIn = RX;
`endif

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txFifo (
        .clk(clk), .rst(rst), .i_push(w_txPush), .i_pop(w_txPop), .i_data(UDI),
        .o_data(w_txData), .o_count(w_txCount), .o_full(w_txFull), .o_empty(w_txEmpty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rxFifo (
        .clk(clk), .rst(rst), .i_push(w_rxPush), .i_pop(w_rxPop), .i_data(w_rxByte),
        .o_data(w_rxData), .o_count(w_rxCount), .o_full(w_rxFull), .o_empty(w_rxEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie   <= '0;
            r_cfg  <= '0;
            r_div  <= DIV_RST;
            r_tovf <= 1'b0;
            r_ovf  <= 1'b0;
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (WRITES[W_IE])   r_ie <= UDI[3:0];
            if (WRITES[W_DIVL]) r_div[7:0] <= UDI;
            if (WRITES[W_DIVH]) r_div[DIVW-1:8] <= UDI[DIVW-9:0];
            if (WRITES[W_CFG])  r_cfg <= UDI[3:0];
            // A flag raised on the same edge as a status read survives the clear.
            r_tovf <= (w_txPush & w_txFull & ~w_txPop) | (r_tovf & ~READS[R_STAT]);
            r_ovf  <= (w_rxPush & w_rxFull & ~w_rxPop) | (r_ovf  & ~READS[R_STAT]);
            r_ferr <= w_ferrSet | (r_ferr & ~READS[R_STAT]);
            r_perr <= w_perrSet | (r_perr & ~READS[R_STAT]);
        end
    end

    always_comb begin
        w_txStateNext = r_txState;
        w_txPop       = 1'b0;
        w_txLoad      = 1'b0;
        w_txBit       = 1'b1;
        case (r_txState)
            ST_IDLE: begin
                if (!w_txEmpty) begin
                    w_txPop       = 1'b1;
                    w_txLoad      = 1'b1;
                    w_txStateNext = ST_START;
                end
            end
            ST_START: begin
                w_txBit = 1'b0;
                if (w_txTick) w_txStateNext = ST_DATA;
            end
            ST_DATA: begin
                w_txBit = r_txShift[0];
                if (w_txTick && r_txIdx == w_lastIdx) begin
                    w_txStateNext = r_cfg[C_PEN] ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_txBit = r_txPar;
                if (w_txTick) w_txStateNext = ST_STOP;
            end
            ST_STOP: begin
                if (w_txTick) begin
                    if (!w_txEmpty) begin
                        w_txPop       = 1'b1;
                        w_txLoad      = 1'b1;
                        w_txStateNext = ST_START;
                    end else begin
                        w_txStateNext = ST_IDLE;
                    end
                end
            end
            default: w_txStateNext = ST_IDLE;
        endcase
    end

    // The pin is registered from the state, so it lags the FSM by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txState <= ST_IDLE;
            r_txCnt   <= '0;
            r_txIdx   <= '0;
            r_txShift <= '0;
            r_txPar   <= 1'b0;
            r_txPin   <= 1'b1;
        end else begin
            r_txState <= w_txStateNext;
            r_txPin   <= w_txBit;
            if (w_txLoad) begin
                r_txShift <= w_txData;
                r_txPar   <= calcParity(w_txData, r_cfg[C_EIGHT], r_cfg[C_OHEL]);
                r_txCnt   <= w_div;
            end else if (r_txState != ST_IDLE) begin
                if (w_txTick) begin
                    r_txCnt <= w_div;
                    if (r_txState == ST_START) r_txIdx <= '0;
                    if (r_txState == ST_DATA) begin
                        r_txShift <= {1'b0, r_txShift[7:1]};
                        r_txIdx   <= r_txIdx + 3'd1;
                    end
                end else begin
                    r_txCnt <= r_txCnt - DIVW'(1);
                end
            end
        end
    end

    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxPush      = 1'b0;
        w_ferrSet     = 1'b0;
        w_perrSet     = 1'b0;
        w_rxByte      = r_cfg[C_EIGHT] ? r_rxShift : {1'b0, r_rxShift[7:1]};
        case (r_rxState)
            ST_IDLE: begin
                if (w_rxFall) w_rxStateNext = ST_START;
            end
            ST_START: begin
                if (w_rxTick) w_rxStateNext = r_rxSync2 ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_rxTick && r_rxIdx == w_lastIdx) begin
                    w_rxStateNext = r_cfg[C_PEN] ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_rxTick) w_rxStateNext = ST_STOP;
            end
            ST_STOP: begin
                if (w_rxTick) begin
                    w_rxPush      = 1'b1;
                    w_ferrSet     = ~r_rxSync2;
                    w_perrSet     = r_cfg[C_PEN] &&
                                    (r_rxParBit != calcParity(w_rxByte, r_cfg[C_EIGHT], r_cfg[C_OHEL]));
                    w_rxStateNext = ST_IDLE;
                end
            end
            default: w_rxStateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxSync1  <= 1'b1;
            r_rxSync2  <= 1'b1;
            r_rxPrev   <= 1'b1;
            r_rxState  <= ST_IDLE;
            r_rxCnt    <= '0;
            r_rxIdx    <= '0;
            r_rxShift  <= '0;
            r_rxParBit <= 1'b0;
        end else begin
            r_rxSync1 <= w_rxIn;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
            r_rxState <= w_rxStateNext;
            if (r_rxState == ST_IDLE) begin
                if (w_rxFall) r_rxCnt <= w_div >> 1;
            end else if (w_rxTick) begin
                r_rxCnt <= w_div;
                if (r_rxState == ST_START)  r_rxIdx <= '0;
                if (r_rxState == ST_PARITY) r_rxParBit <= r_rxSync2;
                if (r_rxState == ST_DATA) begin
                    r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
                    r_rxIdx   <= r_rxIdx + 3'd1;
                end
            end else begin
                r_rxCnt <= r_rxCnt - DIVW'(1);
            end
        end
    end

    always_comb begin
        w_status            = '0;
        w_status[S_TXFULL]  = w_txFull;
        w_status[S_TXEMPTY] = w_txEmpty;
        w_status[S_TOVF]    = r_tovf;
        w_status[S_OVF]     = r_ovf;
        w_status[S_FERR]    = r_ferr;
        w_status[S_PERR]    = r_perr;
        w_status[S_TXRDY]   = ~w_txFull;
        w_status[S_RXRDY]   = ~w_rxEmpty;
    end

    always_comb begin
        UDO = 8'h00;
        if (READS[R_RXDATA]) begin
            UDO = w_rxEmpty ? 8'h00 : w_rxData;
        end else if (READS[R_STAT]) begin
            UDO = w_status;
        end else if (READS[R_RXCNT]) begin
            UDO = 8'(w_rxCount);
        end else if (READS[R_TXCNT]) begin
            UDO = 8'(w_txCount);
        end
    end

    assign UART_INT = |(r_ie & {r_tovf | r_ovf | r_ferr | r_perr,
                                w_txEmpty & (r_txState == ST_IDLE),
                                ~w_rxEmpty,
                                w_rxFull});

endmodule

// File: tb/tb_uart_fifo_top.sv
// Directed self-checking bench for uart_fifo_top with hand-computed expectations.
module tb_uart_fifo_top;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] writes;
    logic [7:0] reads;
    logic [7:0] udi;
    logic       rxDrive;
    logic       extLoop;
    logic       rxPin;
    logic       txPin;
    logic       uartInt;
    logic [7:0] udo;

    int vectors;
    int miscompares;

    assign rxPin = extLoop ? txPin : rxDrive;

    uart_fifo_top dut (
        .clk(clk), .rst(rst), .WRITES(writes), .READS(reads), .UDI(udi),
        .RX(rxPin), .TX(txPin), .UART_INT(uartInt), .UDO(udo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one strobe cycle starting at a falling edge; returns UDO seen during it.
    task automatic applyStimulus(input logic [7:0] wr, input logic [7:0] rd,
                                 input logic [7:0] d, output logic [7:0] seen);
        writes = wr;
        reads  = rd;
        udi    = d;
        #1;
        seen = udo;
        @(posedge clk);
        @(negedge clk);
        writes = '0;
        reads  = '0;
        udi    = '0;
    endtask

    task automatic wrReg(input int idx, input logic [7:0] d);
        logic [7:0] dummy;
        applyStimulus(8'h01 << idx, 8'h00, d, dummy);
    endtask

    task automatic rdReg(input int idx, output logic [7:0] val);
        applyStimulus(8'h00, 8'h01 << idx, 8'h00, val);
    endtask

    // Serial frame on RX at 10 clocks per bit (DIV=9), followed by idle time.
    task automatic sendFrame(input logic [7:0] data, input int nBits, input logic usePar,
                             input logic parBit, input logic stopBit);
        rxDrive = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nBits; i++) begin
            rxDrive = data[i];
            repeat (10) @(negedge clk);
        end
        if (usePar) begin
            rxDrive = parBit;
            repeat (10) @(negedge clk);
        end
        rxDrive = stopBit;
        repeat (10) @(negedge clk);
        rxDrive = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (txPin !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b expected 1", txPin); end
        vectors++;
        if (uartInt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_int: got %b expected 0", uartInt); end
        vectors++;
        if (udo !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_udo: got %h expected 00", udo); end
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h42) begin miscompares++; $display("[TB] FAIL reset_status: got %h expected 42", v); end
        rdReg(R_TXCNT, v);
        vectors++;
        if (v !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_txcnt: got %h expected 00", v); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        logic [7:0] v;
        frame = {1'b1, 8'hA5, 1'b0};
        wrReg(W_DIVL, 8'd9);
        wrReg(W_DIVH, 8'd0);
        wrReg(W_CFG, 8'h08);
        wrReg(W_TXDATA, 8'hA5);
        vectors++;
        if (txPin !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_lat0: got %b expected 1", txPin); end
        @(negedge clk);
        vectors++;
        if (txPin !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_lat1: got %b expected 1", txPin); end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                vectors++;
                if (txPin !== frame[k]) begin
                    miscompares++;
                    $display("[TB] FAIL tx_bit%0d_clk%0d: got %b expected %b", k, j, txPin, frame[k]);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (txPin !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_idle: got %b expected 1", txPin); end
        rdReg(R_TXCNT, v);
        vectors++;
        if (v !== 8'h00) begin miscompares++; $display("[TB] FAIL tx_cnt_after: got %h expected 00", v); end
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        logic       found;
        logic       txLow;
        found = 1'b0;
        txLow = 1'b0;
`ifndef UART_LOOPBACK_EN
        extLoop = 1'b1;
`endif
        wrReg(W_CFG, 8'h0F);
        wrReg(W_TXDATA, 8'h3C);
        for (int i = 0; i < 400 && !found; i++) begin
            if (txPin === 1'b0) txLow = 1'b1;
            rdReg(R_RXCNT, v);
            if (v !== 8'h00) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL loop_rxrdy: got %b expected 1", found); end
`ifdef UART_LOOPBACK_EN
        vectors++;
        if (txLow !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_pin_held: got %b expected 0", txLow); end
`endif
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h43) begin miscompares++; $display("[TB] FAIL loop_status: got %h expected 43", v); end
        rdReg(R_RXDATA, v);
        vectors++;
        if (v !== 8'h3C) begin miscompares++; $display("[TB] FAIL loop_data: got %h expected 3c", v); end
        repeat (30) @(negedge clk);
        extLoop = 1'b0;
        wrReg(W_CFG, 8'h08);
    endtask

    task automatic test_rx_errors();
        logic [7:0] v;
        sendFrame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h4B) begin miscompares++; $display("[TB] FAIL ferr_status: got %h expected 4b", v); end
        rdReg(R_RXDATA, v);
        vectors++;
        if (v !== 8'h5A) begin miscompares++; $display("[TB] FAIL ferr_data: got %h expected 5a", v); end
        wrReg(W_CFG, 8'h0C);
        sendFrame(8'h01, 8, 1'b1, 1'b0, 1'b1);
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h47) begin miscompares++; $display("[TB] FAIL perr_status: got %h expected 47", v); end
        rdReg(R_RXDATA, v);
        vectors++;
        if (v !== 8'h01) begin miscompares++; $display("[TB] FAIL perr_data: got %h expected 01", v); end
        sendFrame(8'h03, 8, 1'b1, 1'b0, 1'b1);
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h43) begin miscompares++; $display("[TB] FAIL par_ok_status: got %h expected 43", v); end
        rdReg(R_RXDATA, v);
        vectors++;
        if (v !== 8'h03) begin miscompares++; $display("[TB] FAIL par_ok_data: got %h expected 03", v); end
        wrReg(W_CFG, 8'h00);
        sendFrame(8'hD5, 7, 1'b0, 1'b0, 1'b1);
        rdReg(R_RXDATA, v);
        vectors++;
        if (v !== 8'h55) begin miscompares++; $display("[TB] FAIL rx7_data: got %h expected 55", v); end
        wrReg(W_CFG, 8'h08);
    endtask

    task automatic test_rx_overflow();
        logic [7:0] v;
        for (int i = 0; i < 17; i++) begin
            sendFrame(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
        end
        rdReg(R_RXCNT, v);
        vectors++;
        if (v !== 8'h10) begin miscompares++; $display("[TB] FAIL ovf_count: got %h expected 10", v); end
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h53) begin miscompares++; $display("[TB] FAIL ovf_status: got %h expected 53", v); end
        for (int i = 0; i < 16; i++) begin
            rdReg(R_RXDATA, v);
            vectors++;
            if (v !== 8'h10 + 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL ovf_drain%0d: got %h expected %h", i, v, 8'h10 + 8'(i));
            end
        end
        rdReg(R_RXDATA, v);
        vectors++;
        if (v !== 8'h00) begin miscompares++; $display("[TB] FAIL empty_read: got %h expected 00", v); end
    endtask

    task automatic test_interrupt();
        logic [7:0] v;
        wrReg(W_IE, 8'h02);
        vectors++;
        if (uartInt !== 1'b0) begin miscompares++; $display("[TB] FAIL int_idle: got %b expected 0", uartInt); end
        sendFrame(8'h77, 8, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (uartInt !== 1'b1) begin miscompares++; $display("[TB] FAIL int_rxrdy: got %b expected 1", uartInt); end
        rdReg(R_RXDATA, v);
        vectors++;
        if (v !== 8'h77) begin miscompares++; $display("[TB] FAIL int_data: got %h expected 77", v); end
        vectors++;
        if (uartInt !== 1'b0) begin miscompares++; $display("[TB] FAIL int_cleared: got %b expected 0", uartInt); end
        wrReg(W_IE, 8'h04);
        vectors++;
        if (uartInt !== 1'b1) begin miscompares++; $display("[TB] FAIL int_txempty: got %b expected 1", uartInt); end
        wrReg(W_IE, 8'h00);
    endtask

    task automatic test_glitch();
        logic [7:0] v;
        rxDrive = 1'b0;
        @(negedge clk);
        rxDrive = 1'b1;
        repeat (40) @(negedge clk);
        rdReg(R_RXCNT, v);
        vectors++;
        if (v !== 8'h00) begin miscompares++; $display("[TB] FAIL glitch_count: got %h expected 00", v); end
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h42) begin miscompares++; $display("[TB] FAIL glitch_status: got %h expected 42", v); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] v;
        wrReg(W_DIVL, 8'hFF);
        wrReg(W_DIVH, 8'hFF);
        wrReg(W_TXDATA, 8'h00);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            wrReg(W_TXDATA, 8'(i));
        end
        rdReg(R_TXCNT, v);
        vectors++;
        if (v !== 8'h10) begin miscompares++; $display("[TB] FAIL tovf_count: got %h expected 10", v); end
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'hA0) begin miscompares++; $display("[TB] FAIL tovf_status: got %h expected a0", v); end
        rdReg(R_STAT, v);
        vectors++;
        if (v !== 8'h80) begin miscompares++; $display("[TB] FAIL tovf_cleared: got %h expected 80", v); end
        vectors++;
        if (txPin !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_low: got %b expected 0", txPin); end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (txPin !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_reset_tx: got %b expected 1", txPin); end
        rst = 1'b0;
        rdReg(R_TXCNT, v);
        vectors++;
        if (v !== 8'h00) begin miscompares++; $display("[TB] FAIL midframe_reset_cnt: got %h expected 00", v); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        writes      = '0;
        reads       = '0;
        udi         = '0;
        rxDrive     = 1'b1;
        extLoop     = 1'b0;
        @(negedge clk);
        test_reset();
        test_tx_frame();
        test_loopback();
        test_rx_errors();
        test_rx_overflow();
        test_interrupt();
        test_glitch();
        test_tx_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
